mux8_2_bank_out_reorder: RTL and testbench

//  Return-path crossbar for the 8-bank polynomial coefficient memory. The inbound mux

---
 rtl/mux8_2_bank_out_reorder_pkg.sv | 31 +++
 rtl/mux8_2_bank_out_reorder_bank_sel_delay.sv | 38 +++
 rtl/mux8_2_bank_out_reorder.sv | 77 +++++++
 tb/tb_mux8_2_bank_out_reorder.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux8_2_bank_out_reorder_pkg.sv
// Shared constants for the 8-bank coefficient memory crossbars (inbound and return path).
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
package mux8_2_bank_out_reorder_pkg;

   localparam int LANES     = 8;
   localparam int SEL_W     = 3;
   localparam int SEL_BUS_W = LANES * SEL_W;

   // Bank index as carried by one lane select field
   typedef logic [SEL_W-1:0] bank_idx_t;

   // One stage of the select delay line
   typedef struct packed {
      logic                 valid;
      logic [SEL_BUS_W-1:0] sel;
   } sel_stage_t;

   // True when any two lanes address the same bank (28 pairwise comparators)
   function automatic logic sel_has_dup(input logic [SEL_BUS_W-1:0] sel);
      logic dup;
      dup = 1'b0;
      for (int a = 0; a < LANES - 1; a++) begin
         for (int b = a + 1; b < LANES; b++) begin
            if (sel[a*SEL_W +: SEL_W] == sel[b*SEL_W +: SEL_W]) dup = 1'b1;
         end
      end
      return dup;
   endfunction

endpackage

// File: rtl/mux8_2_bank_out_reorder_bank_sel_delay.sv
// Delays {valid, lane selects} so they line up with bank read data.
// Latency: RD_LAT cycles, in_* to out_*; advances every cycle.
// Backpressure: none (no stall); clear drops every in-flight entry on the next edge.
// Ports: clk, rst_n (async active-low); in_valid/in_sel request side; clear sync drop;
//        out_valid/out_sel the entry issued RD_LAT cycles earlier.
module mux8_2_bank_out_reorder_bank_sel_delay
   import mux8_2_bank_out_reorder_pkg::*;
#(
   parameter int RD_LAT = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   input  logic [SEL_BUS_W-1:0] in_sel,
   input  logic                 clear,
   output logic                 out_valid,
   output logic [SEL_BUS_W-1:0] out_sel
);

   sel_stage_t stage_q [RD_LAT];

   // Selects of invalid entries are forced to 0 so the line content is deterministic.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int s = 0; s < RD_LAT; s++) stage_q[s] <= '0;
      end else begin
         stage_q[0] <= (in_valid && !clear) ? sel_stage_t'{valid: 1'b1, sel: in_sel}
                                             : sel_stage_t'('0);
         for (int s = 1; s < RD_LAT; s++) begin
            stage_q[s] <= (stage_q[s-1].valid && !clear) ? stage_q[s-1] : sel_stage_t'('0);
         end
      end
   end

   assign out_valid = stage_q[RD_LAT-1].valid;
   assign out_sel   = stage_q[RD_LAT-1].sel;

endmodule

// File: rtl/mux8_2_bank_out_reorder.sv
// Return-path crossbar: lane i gets the read word of the bank it addressed at request time.
// Latency: req_valid at t -> lane_valid/lane_data at t+RD_LAT+1; one request per cycle.
// Backpressure: none; flush drops all in-flight requests and clears conflict_err.
// Ports: clk, rst_n (async active-low); req_valid, sel_a {lane7..lane0} 3b bank each;
//        flush; bank_rdata {b7..b0}; lane_valid, lane_data {lane7..lane0}; conflict_err sticky.
module mux8_2_bank_out_reorder
   import mux8_2_bank_out_reorder_pkg::*;
#(
   parameter int DATA_WIDTH = 256,
   parameter int RD_LAT     = 2     // legal 1..8
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        req_valid,
   input  logic [SEL_BUS_W-1:0]        sel_a,
   input  logic                        flush,
   input  logic [LANES*DATA_WIDTH-1:0] bank_rdata,
   output logic                        lane_valid,
   output logic [LANES*DATA_WIDTH-1:0] lane_data,
   output logic                        conflict_err
);

   logic                 valid_d;
   logic [SEL_BUS_W-1:0] sel_d;
   logic [DATA_WIDTH-1:0] bank_word [LANES];

   mux8_2_bank_out_reorder_bank_sel_delay #(
      .RD_LAT (RD_LAT)
   ) u_sel_delay (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (req_valid),
      .in_sel    (sel_a),
      .clear     (flush),
      .out_valid (valid_d),
      .out_sel   (sel_d)
   );

   for (genvar b = 0; b < LANES; b++) begin : g_bank
      assign bank_word[b] = bank_rdata[b*DATA_WIDTH +: DATA_WIDTH];
   end

   // Registered 8:1 mux per lane; data holds when nothing valid arrives or on flush.
   for (genvar l = 0; l < LANES; l++) begin : g_lane
      bank_idx_t             lane_sel;
      logic [DATA_WIDTH-1:0] data_q;

      assign lane_sel = sel_d[l*SEL_W +: SEL_W];

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            data_q <= '0;
         end else if (valid_d && !flush) begin
            data_q <= bank_word[lane_sel];
         end
      end

      assign lane_data[l*DATA_WIDTH +: DATA_WIDTH] = data_q;
   end

   // The delay line clears on flush only at the next edge, so the entry currently
   // at the output must be suppressed here as well.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lane_valid   <= 1'b0;
         conflict_err <= 1'b0;
      end else begin
         lane_valid <= valid_d && !flush;
         if (flush) begin
            conflict_err <= 1'b0;
         end else if (req_valid && sel_has_dup(sel_a)) begin
            conflict_err <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_mux8_2_bank_out_reorder.sv
module tb_mux8_2_bank_out_reorder;

   localparam int W = 32;

   typedef struct {
      int           due;
      logic [255:0] data;
   } exp_t;

   logic         clk;
   logic         rst_n;
   logic         req_valid;
   logic [23:0]  sel_a;
   logic         flush;
   logic [255:0] bank_rdata;

   logic         lv1, lv2, lv8, ce1, ce2, ce8;
   logic [255:0] ld1, ld2, ld8;
   logic         lv [3];
   logic         ce [3];
   logic [255:0] ld [3];

   int   n_assert = 0;
   int   n_fail   = 0;
   int   lat [3]  = '{1, 2, 8};
   exp_t sb [3][$];

   mux8_2_bank_out_reorder #(.DATA_WIDTH(W), .RD_LAT(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .sel_a(sel_a), .flush(flush),
      .bank_rdata(bank_rdata), .lane_valid(lv1), .lane_data(ld1), .conflict_err(ce1));
   mux8_2_bank_out_reorder #(.DATA_WIDTH(W), .RD_LAT(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .sel_a(sel_a), .flush(flush),
      .bank_rdata(bank_rdata), .lane_valid(lv2), .lane_data(ld2), .conflict_err(ce2));
   mux8_2_bank_out_reorder #(.DATA_WIDTH(W), .RD_LAT(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .sel_a(sel_a), .flush(flush),
      .bank_rdata(bank_rdata), .lane_valid(lv8), .lane_data(ld8), .conflict_err(ce8));

   assign lv[0] = lv1;  assign lv[1] = lv2;  assign lv[2] = lv8;
   assign ce[0] = ce1;  assign ce[1] = ce2;  assign ce[2] = ce8;
   assign ld[0] = ld1;  assign ld[1] = ld2;  assign ld[2] = ld8;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [255:0] fill(input logic [31:0] base);
      logic [255:0] r;
      for (int j = 0; j < 8; j++) r[j*W +: W] = base + 32'(j);
      return r;
   endfunction

   function automatic logic [23:0] sel_rot(input int r);
      logic [23:0] s;
      for (int i = 0; i < 8; i++) s[i*3 +: 3] = 3'((i + r) % 8);
      return s;
   endfunction

   function automatic logic [23:0] sel_rev();
      logic [23:0] s;
      for (int i = 0; i < 8; i++) s[i*3 +: 3] = 3'(7 - i);
      return s;
   endfunction

   // lanes 2 and 5 both on bank 4, lane 4 moved to bank 2, bank 5 unused
   function automatic logic [23:0] sel_conf();
      logic [23:0] s;
      s = sel_rot(0);
      s[2*3 +: 3] = 3'd4;
      s[4*3 +: 3] = 3'd2;
      s[5*3 +: 3] = 3'd4;
      return s;
   endfunction

   function automatic logic [31:0] gen(input int c, input int j);
      return (32'(c) << 4) ^ 32'(j) ^ 32'hC0DE_0000;
   endfunction

   function automatic logic [255:0] route(input int c, input logic [23:0] s);
      logic [255:0] r;
      for (int i = 0; i < 8; i++) r[i*W +: W] = gen(c, int'(s[i*3 +: 3]));
      return r;
   endfunction

   task automatic test_reset();
      rst_n = 1'b1; req_valid = 1'b0; sel_a = '0; flush = 1'b0; bank_rdata = '0;
      #2 rst_n = 1'b0;
      #1;
      for (int k = 0; k < 3; k++) begin
         n_assert++;
         if (lv[k] !== 1'b0 || ld[k] !== '0 || ce[k] !== 1'b0) begin
            n_fail++;
            $display("FAIL reset lat=%0d got lv=%b ce=%b data=%h required lv=0 ce=0 data=0",
                     lat[k], lv[k], ce[k], ld[k]);
         end
      end
      repeat (2) @(posedge clk);
      #2 rst_n = 1'b1;
      tick();
   endtask

   task automatic test_identity();
      req_valid = 1'b1; sel_a = sel_rot(0); bank_rdata = '0;
      tick();                                     // t+1
      req_valid = 1'b0; sel_a = '0;
      n_assert++;
      if (lv2 !== 1'b0) begin n_fail++; $display("FAIL id_lv_t1 got %b required 0", lv2); end
      tick();                                     // t+2
      bank_rdata = fill(32'd1);
      n_assert++;
      if (lv2 !== 1'b0) begin n_fail++; $display("FAIL id_lv_t2 got %b required 0", lv2); end
      tick();                                     // t+3
      bank_rdata = '0;
      n_assert++;
      if (lv2 !== 1'b1) begin n_fail++; $display("FAIL id_lv_t3 got %b required 1", lv2); end
      for (int i = 0; i < 8; i++) begin
         n_assert++;
         if (ld2[i*W +: W] !== 32'(i + 1)) begin
            n_fail++;
            $display("FAIL id_lane%0d got %h required %h", i, ld2[i*W +: W], 32'(i + 1));
         end
      end
      n_assert++;
      if (ce2 !== 1'b0) begin n_fail++; $display("FAIL id_conflict got %b required 0", ce2); end
      tick();                                     // t+4
      n_assert++;
      if (lv2 !== 1'b0) begin n_fail++; $display("FAIL id_lv_t4 got %b required 0", lv2); end
      n_assert++;
      if (ld2 !== fill(32'd1)) begin
         n_fail++;
         $display("FAIL id_hold got %h required %h", ld2, fill(32'd1));
      end
   endtask

   task automatic test_back_to_back();
      req_valid = 1'b1; sel_a = sel_rot(1);
      tick();
      sel_a = sel_rev();
      tick();
      req_valid = 1'b0; sel_a = '0; bank_rdata = fill(32'h100);
      tick();
      bank_rdata = fill(32'h200);
      n_assert++;
      if (lv2 !== 1'b1) begin n_fail++; $display("FAIL b2b_lv_first got %b required 1", lv2); end
      for (int i = 0; i < 8; i++) begin
         n_assert++;
         if (ld2[i*W +: W] !== 32'h100 + 32'((i + 1) % 8)) begin
            n_fail++;
            $display("FAIL b2b_rot_lane%0d got %h required %h", i, ld2[i*W +: W],
                     32'h100 + 32'((i + 1) % 8));
         end
      end
      tick();
      bank_rdata = '0;
      n_assert++;
      if (lv2 !== 1'b1) begin n_fail++; $display("FAIL b2b_lv_second got %b required 1", lv2); end
      for (int i = 0; i < 8; i++) begin
         n_assert++;
         if (ld2[i*W +: W] !== 32'h200 + 32'(7 - i)) begin
            n_fail++;
            $display("FAIL b2b_rev_lane%0d got %h required %h", i, ld2[i*W +: W],
                     32'h200 + 32'(7 - i));
         end
      end
      tick();
      n_assert++;
      if (lv2 !== 1'b0) begin n_fail++; $display("FAIL b2b_lv_after got %b required 0", lv2); end
   endtask

   task automatic test_conflict();
      logic [23:0] cs;
      cs = sel_conf();
      req_valid = 1'b0; sel_a = cs;               // duplicate selects without a request
      tick();
      n_assert++;
      if (ce2 !== 1'b0) begin n_fail++; $display("FAIL conf_noreq got %b required 0", ce2); end
      req_valid = 1'b1;
      tick();
      req_valid = 1'b0; sel_a = '0;
      n_assert++;
      if (ce2 !== 1'b1) begin n_fail++; $display("FAIL conf_set got %b required 1", ce2); end
      tick();
      bank_rdata = fill(32'h300);
      n_assert++;
      if (ce2 !== 1'b1) begin n_fail++; $display("FAIL conf_sticky got %b required 1", ce2); end
      tick();
      bank_rdata = '0; flush = 1'b1;
      n_assert++;
      if (lv2 !== 1'b1) begin n_fail++; $display("FAIL conf_lv got %b required 1", lv2); end
      for (int i = 0; i < 8; i++) begin
         n_assert++;
         if (ld2[i*W +: W] !== 32'h300 + 32'(cs[i*3 +: 3])) begin
            n_fail++;
            $display("FAIL conf_lane%0d got %h required %h", i, ld2[i*W +: W],
                     32'h300 + 32'(cs[i*3 +: 3]));
         end
      end
      tick();
      flush = 1'b0;
      n_assert++;
      if (ce2 !== 1'b0) begin n_fail++; $display("FAIL conf_flush got %b required 0", ce2); end
   endtask

   task automatic test_flush();
      logic [255:0] held;
      logic [23:0]  cs;
      cs = sel_conf();
      for (int i = 0; i < 8; i++) held[i*W +: W] = 32'h300 + 32'(cs[i*3 +: 3]);
      req_valid = 1'b1; sel_a = sel_rot(0);
      tick();
      sel_a = sel_rev();
      tick();
      req_valid = 1'b0; sel_a = '0; flush = 1'b1; bank_rdata = fill(32'h400);
      tick();
      // request issued together with flush must be dropped too
      req_valid = 1'b1; sel_a = sel_rot(0); flush = 1'b1; bank_rdata = fill(32'h500);
      n_assert++;
      if (lv2 !== 1'b0) begin n_fail++; $display("FAIL flush_lv_c3 got %b required 0", lv2); end
      tick();
      req_valid = 1'b0; sel_a = '0; flush = 1'b0; bank_rdata = fill(32'h600);
      for (int c = 0; c < 4; c++) begin
         n_assert++;
         if (lv2 !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_lv_c%0d got %b required 0", c + 4, lv2);
         end
         tick();
      end
      bank_rdata = '0;
      n_assert++;
      if (ld2 !== held) begin
         n_fail++;
         $display("FAIL flush_hold got %h required %h", ld2, held);
      end
   endtask

   task automatic test_async_reset();
      req_valid = 1'b1; sel_a = sel_conf();
      tick();
      sel_a = sel_rot(0);
      n_assert++;
      if (ce2 !== 1'b1) begin n_fail++; $display("FAIL arst_pre_conf got %b required 1", ce2); end
      tick();
      sel_a = sel_rot(1); bank_rdata = fill(32'h700);
      tick();
      n_assert++;
      if (lv2 !== 1'b1) begin n_fail++; $display("FAIL arst_pre_lv got %b required 1", lv2); end
      #3 rst_n = 1'b0;
      req_valid = 1'b0; sel_a = '0; bank_rdata = '0;
      #1;
      for (int k = 0; k < 3; k++) begin
         n_assert++;
         if (lv[k] !== 1'b0 || ld[k] !== '0 || ce[k] !== 1'b0) begin
            n_fail++;
            $display("FAIL arst_now lat=%0d got lv=%b ce=%b data=%h required all 0",
                     lat[k], lv[k], ce[k], ld[k]);
         end
      end
      #2 rst_n = 1'b1;
      for (int c = 0; c < 10; c++) begin
         tick();
         for (int k = 0; k < 3; k++) begin
            n_assert++;
            if (lv[k] !== 1'b0) begin
               n_fail++;
               $display("FAIL arst_late lat=%0d cyc=%0d got lane_valid=%b required 0",
                        lat[k], c, lv[k]);
            end
         end
      end
   endtask

   task automatic test_random();
      int   p [8];
      int   tmp, j;
      logic [23:0] perm;
      exp_t e;
      for (int n = 0; n < 1012; n++) begin
         req_valid = (n < 1000) ? ($urandom_range(0, 3) != 0) : 1'b0;
         for (int i = 0; i < 8; i++) p[i] = i;
         for (int i = 7; i > 0; i--) begin
            j = int'($urandom_range(0, i));
            tmp = p[i]; p[i] = p[j]; p[j] = tmp;
         end
         for (int i = 0; i < 8; i++) perm[i*3 +: 3] = 3'(p[i]);
         sel_a      = req_valid ? perm : 24'($urandom);
         bank_rdata = route(n, sel_rot(0));
         if (req_valid) begin
            for (int k = 0; k < 3; k++) begin
               e.due  = n + lat[k] + 1;
               e.data = route(n + lat[k], perm);
               sb[k].push_back(e);
            end
         end
         tick();
         for (int k = 0; k < 3; k++) begin
            if (lv[k]) begin
               n_assert++;
               if (sb[k].size() == 0 || sb[k][0].due != n + 1) begin
                  n_fail++;
                  $display("FAIL rnd_unexpected lat=%0d cyc=%0d got lane_valid=1 required 0",
                           lat[k], n + 1);
               end else begin
                  e = sb[k].pop_front();
                  n_assert++;
                  if (ld[k] !== e.data) begin
                     n_fail++;
                     $display("FAIL rnd_data lat=%0d cyc=%0d got %h required %h",
                              lat[k], n + 1, ld[k], e.data);
                  end
               end
            end else if (sb[k].size() != 0 && sb[k][0].due == n + 1) begin
               n_assert++;
               n_fail++;
               $display("FAIL rnd_missing lat=%0d cyc=%0d got lane_valid=0 required 1",
                        lat[k], n + 1);
               void'(sb[k].pop_front());
            end
         end
      end
      for (int k = 0; k < 3; k++) begin
         n_assert++;
         if (sb[k].size() != 0 || ce[k] !== 1'b0) begin
            n_fail++;
            $display("FAIL rnd_end lat=%0d got pending=%0d conflict=%b required 0 and 0",
                     lat[k], sb[k].size(), ce[k]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_identity();
      test_back_to_back();
      test_conflict();
      test_flush();
      test_async_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
